// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: turns an ASCII hex-digit stream back into a binary word.
// Digits accumulate MSB-first. CR, LF or space ends a token. Malformed
// tokens raise err and are dropped up to the next terminator.
// Build option: define ASCII_HEX_LOWERCASE_EN to accept 'a'-'f' as digits.
//
// state | meaning
// IDLE  | no token in progress, acc/cnt clear
// ACCUM | collecting digits of a token
// HOLD  | word presented on out_*, waiting for out_ready
// SKIP  | bad token seen, discarding up to the next terminator
module ascii_hex_parser #(
    parameter int DIGITS = 8,
    localparam int W  = 4*DIGITS,
    localparam int CW = $clog2(DIGITS+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] SKIP  = 2'd3;

    localparam logic [CW-1:0] CMAX = CW'(DIGITS);

    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          is_digit;
    logic          is_term;
    logic [3:0]    nibble;
    logic          accept;

    // in_ready is a register, so out_ready never reaches it combinationally
    assign accept = in_valid && in_ready;

    // Classify the incoming character and decode its nibble value
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = 4'h0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = in_data[3:0];
        end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
            is_digit = 1'b1;
            nibble   = in_data[3:0] + 4'd9;
`ifdef ASCII_HEX_LOWERCASE_EN
        end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = in_data[3:0] + 4'd9;
`endif
        end else if (in_data == 8'h0D || in_data == 8'h0A || in_data == 8'h20) begin
            is_term = 1'b1;
        end
    end

    // Token FSM: accumulate, emit on terminator, hold until taken, skip bad tokens
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            err      <= 1'b0;
            in_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_digit) begin
                            acc   <= W'({acc, nibble});
                            cnt   <= cnt + CW'(1);
                            state <= ACCUM;
                        end else if (!is_term) begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                            state    <= SKIP;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (cnt == CMAX) begin
                                err      <= 1'b1;
                                err_code <= ERR_OVERFLOW;
                                state    <= SKIP;
                            end else begin
                                // {acc, nibble} is W+4 wide; the cast drops the top nibble
                                acc <= W'({acc, nibble});
                                cnt <= cnt + CW'(1);
                            end
                        end else if (is_term) begin
                            out_data  <= acc;
                            out_count <= cnt;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                            state    <= SKIP;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    if (accept && is_term) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb_ascii_hex_parser: directed token scenarios plus a randomized character
// stream compared against a token-level reference model.
module tb_ascii_hex_parser;

    localparam int DIGITS = 8;
    localparam int W      = 4*DIGITS;
    localparam int CW     = $clog2(DIGITS+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          err;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;
    int hold_viol = 0;

    bit ordy_rand = 1'b0;
    bit ordy_hold = 1'b1;

    logic [W+CW-1:0] obs_w[$];
    logic [W+CW-1:0] exp_w[$];
    logic [1:0]      obs_e[$];
    logic [1:0]      exp_e[$];

    // reference model state: token value, digit count, skipping flag
    longint m_val  = 0;
    int     m_len  = 0;
    bit     m_skip = 1'b0;

    bit            prev_v = 1'b0;
    bit            prev_r = 1'b0;
    logic [W-1:0]  prev_d = '0;
    logic [CW-1:0] prev_c = '0;

    ascii_hex_parser #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = ordy_rand ? ($urandom_range(0, 1) == 1) : ordy_hold;
    end

    // observe transfers, error pulses and output stability at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r &&
                (out_valid !== 1'b1 || out_data !== prev_d || out_count !== prev_c))
                hold_viol++;
            if (out_valid === 1'b1 && in_ready !== 1'b0)
                hold_viol++;
            if (out_valid === 1'b1 && out_ready === 1'b1)
                obs_w.push_back({out_data, out_count});
            if (err === 1'b1)
                obs_e.push_back(err_code);
            prev_v = (out_valid === 1'b1);
            prev_r = out_ready;
            prev_d = out_data;
            prev_c = out_count;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_digit(input byte c, output int v);
        v = 0;
        if (c >= "0" && c <= "9") begin v = c - "0"; return 1'b1; end
        if (c >= "A" && c <= "F") begin v = c - "A" + 10; return 1'b1; end
`ifdef ASCII_HEX_LOWERCASE_EN
        if (c >= "a" && c <= "f") begin v = c - "a" + 10; return 1'b1; end
`endif
        return 1'b0;
    endfunction

    function automatic void model_char(input byte c);
        int v;
        if (m_digit(c, v)) begin
            if (m_skip) begin
            end else if (m_len == DIGITS) begin
                exp_e.push_back(2'b10);
                m_skip = 1'b1;
            end else begin
                m_val = m_val * 16 + v;
                m_len++;
            end
        end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
            if (!m_skip && m_len > 0)
                exp_w.push_back({W'(m_val), CW'(m_len)});
            m_skip = 1'b0;
            m_len  = 0;
            m_val  = 0;
        end else if (!m_skip) begin
            exp_e.push_back(2'b01);
            m_skip = 1'b1;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        obs_w.delete(); exp_w.delete(); obs_e.delete(); exp_e.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_val = 0; m_len = 0; m_skip = 1'b0;
    endtask

    // present one character, wait for acceptance, update the model
    task automatic send_char(input byte c);
        int  budget;
        bit  taken;
        budget = 200;
        taken  = 1'b0;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_data  = c;
        in_valid = 1'b1;
        while (!taken && budget > 0) begin
            @(negedge clk);
            taken = (in_ready === 1'b1);
            @(posedge clk); #1;
            budget--;
        end
        in_valid = 1'b0;
        if (!taken) begin
            total++; bad++;
            $display("FAIL send_timeout char=%02h in_ready=%b want=1", c, in_ready);
        end else begin
            model_char(c);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_count !== '0) begin bad++; $display("FAIL reset_out_count got=%0d want=0", out_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code got=%b want=00", err_code); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("1A2B\r"); idle(10);
        total++; if (obs_w.size() != 1 || obs_w[0] !== {32'h00001A2B, 4'd4}) begin bad++;
            $display("FAIL basic_word got=%h n=%0d want=%h", obs_w.size() > 0 ? obs_w[0] : '0, obs_w.size(), {32'h00001A2B, 4'd4}); end
        total++; if (obs_e.size() != 0) begin bad++; $display("FAIL basic_err pulses=%0d want=0", obs_e.size()); end
    endtask

    task automatic test_stall();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b0;
        idle(2);
        send_str("DEADBEEF\n");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_count !== 4'd8 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h c=%0d rdy=%b want v=1 d=deadbeef c=8 rdy=0",
                         i, out_valid, out_data, out_count, in_ready);
            end
            @(posedge clk); #1;
        end
        ordy_hold = 1'b1;
        send_str("7 "); idle(10);
        total++; if (obs_w.size() != 2 || obs_w[0] !== {32'hDEADBEEF, 4'd8} || obs_w[1] !== {32'h00000007, 4'd1}) begin bad++;
            $display("FAIL stall_words n=%0d first=%h want n=2 deadbeef/8 then 7/1", obs_w.size(), obs_w.size() > 0 ? obs_w[0] : '0); end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL stall_stability violations=%0d want=0", hold_viol); end
    endtask

    task automatic test_overflow();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("123456789 "); idle(5);
        total++; if (obs_e.size() != 1 || obs_e[0] !== 2'b10) begin bad++;
            $display("FAIL overflow_err n=%0d code=%b want n=1 code=10", obs_e.size(), obs_e.size() > 0 ? obs_e[0] : 2'b00); end
        total++; if (obs_w.size() != 0) begin bad++; $display("FAIL overflow_no_word n=%0d want=0", obs_w.size()); end
        send_str("5\r"); idle(5);
        total++; if (obs_w.size() != 1 || obs_w[0] !== {32'h00000005, 4'd1}) begin bad++;
            $display("FAIL overflow_next got=%h n=%0d want=%h", obs_w.size() > 0 ? obs_w[0] : '0, obs_w.size(), {32'h5, 4'd1}); end
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL overflow_code_hold got=%b want=10", err_code); end
    endtask

    task automatic test_illegal();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("4G2\r"); idle(5);
        total++; if (obs_e.size() != 1 || obs_e[0] !== 2'b01) begin bad++;
            $display("FAIL illegal_err n=%0d code=%b want n=1 code=01", obs_e.size(), obs_e.size() > 0 ? obs_e[0] : 2'b00); end
        total++; if (obs_w.size() != 0) begin bad++; $display("FAIL illegal_no_word n=%0d want=0", obs_w.size()); end
        send_str("3\r"); idle(5);
        total++; if (obs_w.size() != 1 || obs_w[0] !== {32'h00000003, 4'd1}) begin bad++;
            $display("FAIL illegal_recover got=%h n=%0d want=%h", obs_w.size() > 0 ? obs_w[0] : '0, obs_w.size(), {32'h3, 4'd1}); end
    endtask

    task automatic test_lowercase();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("ff\r"); idle(5);
`ifdef ASCII_HEX_LOWERCASE_EN
        total++; if (obs_w.size() != 1 || obs_w[0] !== {32'h000000FF, 4'd2}) begin bad++;
            $display("FAIL lower_word got=%h n=%0d want=%h", obs_w.size() > 0 ? obs_w[0] : '0, obs_w.size(), {32'hFF, 4'd2}); end
        total++; if (obs_e.size() != 0) begin bad++; $display("FAIL lower_err pulses=%0d want=0", obs_e.size()); end
`else
        total++; if (obs_e.size() != 1 || obs_e[0] !== 2'b01) begin bad++;
            $display("FAIL lower_err n=%0d code=%b want n=1 code=01", obs_e.size(), obs_e.size() > 0 ? obs_e[0] : 2'b00); end
        total++; if (obs_w.size() != 0) begin bad++; $display("FAIL lower_no_word n=%0d want=0", obs_w.size()); end
`endif
    endtask

    task automatic test_empty();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("\r \n"); idle(5);
        total++; if (obs_w.size() != 0 || obs_e.size() != 0) begin bad++;
            $display("FAIL empty_tokens words=%0d errs=%0d want 0/0", obs_w.size(), obs_e.size()); end
    endtask

    task automatic test_reset_mid();
        clear_q(); ordy_rand = 1'b0; ordy_hold = 1'b1;
        send_str("AB");
        do_reset();
        send_str("C\r"); idle(5);
        total++; if (obs_w.size() != 1 || obs_w[0] !== {32'h0000000C, 4'd1}) begin bad++;
            $display("FAIL reset_mid got=%h n=%0d want=%h", obs_w.size() > 0 ? obs_w[0] : '0, obs_w.size(), {32'hC, 4'd1}); end
    endtask

    task automatic test_random();
        byte c;
        string ill;
        ill = "G@/:`gz#~";
        clear_q(); ordy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: c = byte'("0" + $urandom_range(0, 9));
                3, 4:    c = byte'("A" + $urandom_range(0, 5));
                5:       c = byte'("a" + $urandom_range(0, 5));
                6, 7: begin
                    case ($urandom_range(0, 2))
                        0: c = 8'h0D;
                        1: c = 8'h0A;
                        default: c = 8'h20;
                    endcase
                end
                8: c = ill[$urandom_range(0, ill.len() - 1)];
                default: c = byte'($urandom_range(0, 255));
            endcase
            send_char(c);
        end
        send_char(8'h0D);
        idle(60);
        ordy_rand = 1'b0; ordy_hold = 1'b1;
        idle(5);
        total++; if (obs_w.size() != exp_w.size()) begin bad++;
            $display("FAIL random_word_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            total++; if (obs_w[i] !== exp_w[i]) begin bad++;
                $display("FAIL random_word idx=%0d got=%h want=%h", i, obs_w[i], exp_w[i]); end
        end
        total++; if (obs_e.size() != exp_e.size()) begin bad++;
            $display("FAIL random_err_count got=%0d want=%0d", obs_e.size(), exp_e.size()); end
        for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
            total++; if (obs_e[i] !== exp_e[i]) begin bad++;
                $display("FAIL random_err idx=%0d got=%b want=%b", i, obs_e[i], exp_e[i]); end
        end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL random_stability violations=%0d want=0", hold_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_illegal();
        test_lowercase();
        test_empty();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascii_hex_parser.md
Name: ascii_hex_parser

Overview:
- Receives an ASCII byte stream (UART RX side) and converts hex-digit characters back to a binary word. It is the inverse of the nibble-to-ASCII-hex converter on the transmit path.
- Digits accumulate MSB-first. A terminator character emits the word on a valid/ready output.
- Malformed tokens are flagged and discarded.

Parameters:
- DIGITS, 8, maximum hex digits per token. Must be ≥1.
- Derived localparam W = 4*DIGITS, the output word width.
- Derived localparam CW = $clog2(DIGITS+1), the digit-count width.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  ASCII character
- in_valid  in  1  in_data valid
- in_ready  out  1  parser can accept a character
- out_data  out  W  parsed word, right-aligned, zero-extended
- out_count  out  CW  number of digits in the token (1..DIGITS)
- out_valid  out  1  out_data/out_count valid
- out_ready  in  1  downstream accepts the word
- err  out  1  one-cycle pulse on a token error
- err_code  out  2  01 = illegal character, 10 = digit overflow; holds its value until the next error

Behaviour:
- Reset: all outputs are 0 on the clock edge with rst high. State goes to IDLE and the accumulator and count are cleared.
  - rst overrides everything, including a pending out_valid. The pending word is lost.
  - in_ready is 1 from the first cycle after rst deasserts.
- Input handshake: a character is consumed on a cycle with in_valid && in_ready.
  - in_ready = 1 in IDLE, ACCUM and SKIP; 0 in HOLD.
- Character classes:
  - digit: 0x30–0x39 → 0–9; 0x41–0x46 → A–F (10–15); lowercase per the optional feature.
  - terminator: 0x0D, 0x0A or 0x20.
  - illegal: anything else.
- Accumulate rule: acc <= {acc[W-5:0], nibble}; cnt <= cnt+1.
- IDLE (acc = 0, cnt = 0):
  - digit → accumulate, go to ACCUM.
  - terminator → ignored, stay in IDLE (empty tokens produce no output).
  - illegal → err pulse, err_code = 01, go to SKIP.
- ACCUM:
  - digit with cnt < DIGITS → accumulate.
  - digit with cnt == DIGITS → err pulse, err_code = 10, go to SKIP.
  - terminator → register out_data = acc and out_count = cnt, out_valid = 1, go to HOLD. Latency is 1 cycle: the terminator is accepted at edge N and out_valid is seen after edge N.
  - illegal → err pulse, err_code = 01, go to SKIP.
- HOLD:
  - out_valid, out_data and out_count are stable until out_valid && out_ready.
  - On that transfer: out_valid <= 0, acc and cnt cleared, go to IDLE. in_ready = 1 from the next cycle.
  - No combinational path from out_ready to in_ready.
- SKIP:
  - Consumes and discards characters until a terminator arrives.
  - On the terminator: clear acc and cnt, go to IDLE, no output.
  - Further illegal characters or overflow digits in SKIP do not re-pulse err.
- err is asserted for exactly the cycle after the offending character is accepted.
- Stalled input (in_valid low) in any state: no state change.

Optional Feature:
- Macro: ASCII_HEX_LOWERCASE_EN.
- Defined: 0x61–0x66 (a–f) decode to 10–15, identical to uppercase.
- Undefined: 0x61–0x66 are illegal characters (err_code = 01, go to SKIP).

Test Plan:
- "1A2B\r" with DIGITS = 8, out_ready = 1 → out_valid for one cycle, out_data = 0x00001A2B, out_count = 4, err never asserted.
- "DEADBEEF\n" with out_ready held 0 for 5 cycles, then followed by "7 " → out_data = 0xDEADBEEF held stable with in_ready = 0 throughout the stall. After the transfer, the next word is 0x00000007 with out_count = 1.
- "123456789 " with DIGITS = 8 → err pulse on the 9th digit, err_code = 10, no output. The following "5\r" yields out_data = 0x00000005.
- "4G2\r" → err pulse after 'G' (0x47), err_code = 01, remaining "2\r" discarded, no output, state returns to IDLE.
- "ff\r":
  - with ASCII_HEX_LOWERCASE_EN defined → out_data = 0x000000FF, out_count = 2.
  - without it → err, err_code = 01, no output.
- "\r \n" only → no out_valid and no err. Also: send "AB", then assert rst for 1 cycle, then send "C\r" → out_data = 0x0000000C, out_count = 1.
